// File: rtl/temp_sample_sched_pkg.sv
// temp_sched_pkg: shared widths, display-mode and sampler-state types.
package temp_sched_pkg;
    localparam int TEMP_W = 13;
    localparam int SUM_W = 15;
    typedef logic signed [TEMP_W-1:0] temp_t;
    typedef enum logic [1:0] {MODE_CUR, MODE_AVG, MODE_MIN, MODE_MAX} disp_mode_t;
    typedef enum logic [1:0] {S_EMPTY, S_RUN, S_STALE} samp_state_t;
endpackage

// File: rtl/temp_sample_sched_if.sv
// temp_sample_sched_if: sensor/test inputs and display-path outputs of the scheduler.
interface temp_sample_sched_if;
    import temp_sched_pkg::*;
    logic       tmp_rdy;
    logic       tmp_err;
    temp_t      temp;
    logic       tc_enb;
    temp_t      sw_test;
    logic       mode_btn;
    logic       clr_minmax;
    temp_t      disp_temp;
    disp_mode_t disp_mode;
    logic       sample_tick;
    logic       stale;
    logic       have_data;
    modport master (
        output tmp_rdy, tmp_err, temp, tc_enb, sw_test, mode_btn, clr_minmax,
        input  disp_temp, disp_mode, sample_tick, stale, have_data
    );
    modport slave (
        input  tmp_rdy, tmp_err, temp, tc_enb, sw_test, mode_btn, clr_minmax,
        output disp_temp, disp_mode, sample_tick, stale, have_data
    );
endinterface

// File: rtl/temp_hist_avg.sv
// temp_hist_avg: 4-deep sample history with fill count and registered running sum.
module temp_hist_avg
    import temp_sched_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_push,
    input  logic  i_flush,
    input  temp_t i_sample,
    output temp_t o_newest,
    output temp_t o_avg
);
    temp_t                   r_hist [4];
    logic [2:0]              r_fill;
    logic signed [SUM_W-1:0] r_sum;
    logic signed [SUM_W-1:0] w_sum;
    // Running sum: the oldest entry is zero until the history is full.
    assign w_sum = r_sum + SUM_W'(i_sample) - SUM_W'(r_hist[3]);
    assign o_newest = r_hist[0];
    assign o_avg = (r_fill == 3'd4) ? temp_t'(r_sum >>> 2) : r_hist[0];
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_hist <= '{default: '0};
            r_fill <= '0;
            r_sum  <= '0;
        end else if (i_push) begin
            r_hist <= '{i_sample, r_hist[0], r_hist[1], r_hist[2]};
            r_fill <= (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
            r_sum  <= w_sum;
        end
    end
endmodule

// File: rtl/temp_sample_sched.sv
// temp_sample_sched: periodic sampler, history/min/max tracking and display-source select.
module temp_sample_sched
    import temp_sched_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 25_000_000,
    parameter int STALE_LIMIT   = 4
) (
    input logic                clk,
    input logic                rst,
    temp_sample_sched_if.slave bus
);
    localparam int TW = $clog2(SAMPLE_CYCLES);
    localparam int MW = $clog2(STALE_LIMIT + 1);
    logic [TW-1:0] r_timer;
    logic          r_tick;
    logic          r_tc_d;
    logic [MW-1:0] r_miss;
    samp_state_t   r_state;
    disp_mode_t    r_mode;
    temp_t         r_min, r_max, r_disp;
    logic          r_mm_vld;
    logic          w_flush, w_ok, w_acc, w_miss, w_load, w_have_nxt, w_mm_vld_nxt;
    temp_t         w_sample, w_newest, w_avg, w_latest_nxt, w_min_nxt, w_max_nxt, w_disp_nxt;
    assign w_flush  = bus.tc_enb ^ r_tc_d;
    assign w_ok     = bus.tc_enb | (bus.tmp_rdy & ~bus.tmp_err);
    assign w_acc    = r_tick & ~w_flush & w_ok;
    assign w_miss   = r_tick & ~w_flush & ~w_ok;
    assign w_sample = bus.tc_enb ? bus.sw_test : bus.temp;
    // Trackers reload on the first sample after they were emptied, or on clear-with-accept.
    assign w_load       = w_acc & (bus.clr_minmax | ~r_mm_vld);
    assign w_min_nxt    = (w_load || (w_acc && w_sample < r_min)) ? w_sample : r_min;
    assign w_max_nxt    = (w_load || (w_acc && w_sample > r_max)) ? w_sample : r_max;
    assign w_mm_vld_nxt = ~w_flush & (w_acc | (r_mm_vld & ~bus.clr_minmax));
    assign w_have_nxt   = ~w_flush & (w_acc | (r_state != S_EMPTY));
    assign w_latest_nxt = w_acc ? w_sample : w_newest;
    // Empty trackers hold the last displayed value rather than showing a stale min/max.
    assign w_disp_nxt = !w_have_nxt            ? '0 :
                        (r_mode == MODE_CUR)   ? w_latest_nxt :
                        (r_mode == MODE_AVG)   ? w_avg :
                        !w_mm_vld_nxt          ? r_disp :
                        (r_mode == MODE_MIN)   ? w_min_nxt : w_max_nxt;
    temp_hist_avg u_hist (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_acc),
        .i_flush  (w_flush),
        .i_sample (w_sample),
        .o_newest (w_newest),
        .o_avg    (w_avg)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer  <= TW'(SAMPLE_CYCLES - 1);
            r_tick   <= 1'b0;
            r_tc_d   <= bus.tc_enb;
            r_miss   <= '0;
            r_state  <= S_EMPTY;
            r_mode   <= MODE_CUR;
            r_min    <= '0;
            r_max    <= '0;
            r_mm_vld <= 1'b0;
            r_disp   <= '0;
        end else begin
            r_timer  <= (r_timer == '0) ? TW'(SAMPLE_CYCLES - 1) : r_timer - 1'b1;
            r_tick   <= (r_timer == '0);
            r_tc_d   <= bus.tc_enb;
            r_miss   <= (w_flush || w_acc) ? '0 :
                        (w_miss && r_miss != MW'(STALE_LIMIT)) ? r_miss + 1'b1 : r_miss;
            r_state  <= w_flush ? S_EMPTY :
                        (r_state == S_RUN && w_miss && r_miss == MW'(STALE_LIMIT - 1)) ? S_STALE :
                        (r_state != S_RUN && w_acc) ? S_RUN : r_state;
            r_mode   <= bus.mode_btn ? disp_mode_t'(r_mode + 1'b1) : r_mode;
            r_min    <= w_flush ? '0 : w_min_nxt;
            r_max    <= w_flush ? '0 : w_max_nxt;
            r_mm_vld <= w_mm_vld_nxt;
            r_disp   <= w_disp_nxt;
        end
    end
    assign bus.disp_temp   = r_disp;
    assign bus.disp_mode   = r_mode;
    assign bus.sample_tick = r_tick;
    assign bus.stale       = (r_miss == MW'(STALE_LIMIT));
    assign bus.have_data   = (r_state != S_EMPTY);
endmodule

// File: tb/tb_temp_sample_sched.sv
// tb_temp_sample_sched: directed checks of sampling, averaging, min/max, stale and flush.
module tb_temp_sample_sched;
    import temp_sched_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    temp_sample_sched_if bus ();
    temp_sample_sched #(.SAMPLE_CYCLES(8), .STALE_LIMIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_tick && n < 40);
        if (!bus.sample_tick) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: sample_tick got 0 want 1 within 40 cycles");
        end
    endtask

    task automatic push(input temp_t v);
        bus.temp = v;
        wait_tick();
        @(negedge clk);
    endtask

    task automatic press_mode();
        bus.mode_btn = 1'b1;
        @(negedge clk);
        bus.mode_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tc_enb = 1'b0; bus.tmp_rdy = 1'b1; bus.tmp_err = 1'b0; bus.temp = 13'sd400;
        bus.sw_test = '0; bus.mode_btn = 1'b0; bus.clr_minmax = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.disp_temp !== temp_t'(0)) begin errors++; $display("FAIL reset_disp: got %0d want 0", bus.disp_temp); end
        checks++; if (bus.disp_mode !== MODE_CUR) begin errors++; $display("FAIL reset_mode: got %0d want 0", bus.disp_mode); end
        checks++; if (bus.sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", bus.sample_tick); end
        checks++; if (bus.stale !== 1'b0 || bus.have_data !== 1'b0) begin errors++; $display("FAIL reset_flags: got stale=%0b have=%0b want 0 0", bus.stale, bus.have_data); end
    endtask

    task automatic test_first_sample();
        int n = 0;
        rst = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_tick && n < 40);
        checks++; if (n !== 8) begin errors++; $display("FAIL first_tick_delay: got %0d want 8", n); end
        @(negedge clk);
        checks++; if (bus.disp_temp !== temp_t'(400)) begin errors++; $display("FAIL first_disp: got %0d want 400", bus.disp_temp); end
        checks++; if (bus.have_data !== 1'b1) begin errors++; $display("FAIL first_have: got %0b want 1", bus.have_data); end
        checks++; if (bus.sample_tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %0b want 0", bus.sample_tick); end
    endtask

    task automatic test_history();
        push(13'sd416);
        checks++; if (bus.disp_temp !== temp_t'(416)) begin errors++; $display("FAIL hist_cur416: got %0d want 416", bus.disp_temp); end
        push(-13'sd160);
        push(13'sd0);
        checks++; if (bus.disp_temp !== temp_t'(0)) begin errors++; $display("FAIL hist_cur0: got %0d want 0", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_mode !== MODE_AVG) begin errors++; $display("FAIL hist_mode_avg: got %0d want 1", bus.disp_mode); end
        checks++; if (bus.disp_temp !== temp_t'(164)) begin errors++; $display("FAIL hist_avg: got %0d want 164", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(-160)) begin errors++; $display("FAIL hist_min: got %0d want -160", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(416)) begin errors++; $display("FAIL hist_max: got %0d want 416", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_mode !== MODE_CUR) begin errors++; $display("FAIL hist_mode_wrap: got %0d want 0", bus.disp_mode); end
    endtask

    task automatic test_avg_rounding();
        push(-13'sd1);
        push(13'sd0);
        push(13'sd0);
        push(13'sd0);
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(-1)) begin errors++; $display("FAIL avg_round: got %0d want -1", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(-160)) begin errors++; $display("FAIL round_min: got %0d want -160", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(416)) begin errors++; $display("FAIL round_max: got %0d want 416", bus.disp_temp); end
        press_mode();
    endtask

    task automatic test_stale();
        push(13'sd240);
        checks++; if (bus.disp_temp !== temp_t'(240)) begin errors++; $display("FAIL stale_pre: got %0d want 240", bus.disp_temp); end
        bus.tmp_rdy = 1'b0;
        wait_tick();
        @(negedge clk);
        checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_one_miss: got %0b want 0", bus.stale); end
        bus.tmp_rdy = 1'b1; bus.tmp_err = 1'b1;
        wait_tick();
        @(negedge clk);
        checks++; if (bus.stale !== 1'b1) begin errors++; $display("FAIL stale_set: got %0b want 1", bus.stale); end
        checks++; if (bus.disp_temp !== temp_t'(240)) begin errors++; $display("FAIL stale_hold: got %0d want 240", bus.disp_temp); end
        bus.tmp_err = 1'b0; bus.temp = 13'sd320;
        wait_tick();
        checks++; if (bus.stale !== 1'b1) begin errors++; $display("FAIL stale_tick_cycle: got %0b want 1", bus.stale); end
        @(negedge clk);
        checks++; if (bus.stale !== 1'b0) begin errors++; $display("FAIL stale_clear: got %0b want 0", bus.stale); end
        checks++; if (bus.disp_temp !== temp_t'(320)) begin errors++; $display("FAIL stale_recover: got %0d want 320", bus.disp_temp); end
    endtask

    task automatic test_flush();
        bus.tc_enb = 1'b1; bus.sw_test = -13'sd32;
        @(negedge clk);
        checks++; if (bus.have_data !== 1'b0) begin errors++; $display("FAIL flush_have: got %0b want 0", bus.have_data); end
        checks++; if (bus.disp_temp !== temp_t'(0)) begin errors++; $display("FAIL flush_disp: got %0d want 0", bus.disp_temp); end
        wait_tick();
        @(negedge clk);
        checks++; if (bus.disp_temp !== temp_t'(-32)) begin errors++; $display("FAIL flush_first: got %0d want -32", bus.disp_temp); end
        checks++; if (bus.have_data !== 1'b1) begin errors++; $display("FAIL flush_have_again: got %0b want 1", bus.have_data); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(-32)) begin errors++; $display("FAIL flush_avg_partial: got %0d want -32", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(-32)) begin errors++; $display("FAIL flush_min: got %0d want -32", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(-32)) begin errors++; $display("FAIL flush_max: got %0d want -32", bus.disp_temp); end
        press_mode();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        wait_tick();
        bus.sw_test = 13'sd80; bus.clr_minmax = 1'b1; bus.mode_btn = 1'b1;
        @(negedge clk);
        bus.clr_minmax = 1'b0; bus.mode_btn = 1'b0;
        checks++; if (bus.disp_mode !== MODE_AVG) begin errors++; $display("FAIL b2b_mode: got %0d want 1", bus.disp_mode); end
        checks++; if (bus.disp_temp !== temp_t'(80)) begin errors++; $display("FAIL b2b_cur: got %0d want 80", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(80)) begin errors++; $display("FAIL b2b_min: got %0d want 80", bus.disp_temp); end
        press_mode();
        checks++; if (bus.disp_temp !== temp_t'(80)) begin errors++; $display("FAIL b2b_max: got %0d want 80", bus.disp_temp); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.disp_temp !== temp_t'(0) || bus.disp_mode !== MODE_CUR) begin errors++; $display("FAIL midrst_disp: got %0d/%0d want 0/0", bus.disp_temp, bus.disp_mode); end
        checks++; if (bus.sample_tick !== 1'b0 || bus.stale !== 1'b0 || bus.have_data !== 1'b0) begin errors++; $display("FAIL midrst_flags: got tick=%0b stale=%0b have=%0b want 0 0 0", bus.sample_tick, bus.stale, bus.have_data); end
        rst = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_tick && n < 40);
        checks++; if (n !== 8) begin errors++; $display("FAIL midrst_timer: got %0d want 8", n); end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_history();
        test_avg_rounding();
        test_stale();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
